// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary systolic array.
// Loads one weight tile, streams skewed input vectors, captures skewed outputs.
module systolic_ctrl #(
   parameter int WIDTH = 8,
   parameter int ROW   = 4,
   parameter int COL   = 4,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic [AW:0]       num_vec_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ROW*COL-1:0] ctrl_load_o,
   output logic [ROW*COL-1:0] ctrl_sum_out_o,
   output logic              wb_rd_en_o,
   output logic [RW-1:0]     wb_addr_o,
   output logic [ROW-1:0]    ib_rd_en_o,
   output logic [ROW*AW-1:0] ib_addr_o,
   output logic [COL-1:0]    ob_wr_en_o,
   output logic [COL*AW-1:0] ob_addr_o
);

   // Counter spans the longest state, N+ROW+COL-1, with no wrap.
   localparam int CW = $clog2(DEPTH + ROW + COL + 1);
   localparam int LAT = ROW + 1;
   localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);

   if (WIDTH < 1 || ROW < 1 || COL < 1 || DEPTH < 2) begin : g_bad_cfg
      $error("systolic_ctrl: illegal parameters");
   end

   typedef enum logic [1:0] {IDLE, LOAD, COMP, FIN} state_t;

   state_t         state;
   state_t         state_nx;
   logic [CW-1:0]  cnt;
   logic [AW:0]    n;
   logic [CW-1:0]  last;

   assign last = CW'(n) + CW'(ROW + COL - 1);

   // State, phase counter and latched vector count.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
         cnt   <= '0;
         n     <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state || state == IDLE) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (state == IDLE && start_i) begin
            n <= (num_vec_i > NMAX) ? NMAX : num_vec_i;
         end
      end
   end

   // Phase sequencing; start is only honoured while idle.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start_i) state_nx = LOAD;
         LOAD: begin
            if (cnt == CW'(ROW)) begin
               state_nx = (n == '0) ? FIN : COMP;
            end
         end
         COMP: if (cnt == last) state_nx = FIN;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Strobes and addresses decoded from state and phase counter only.
   always_comb begin
      busy_o         = (state != IDLE);
      done_o         = (state == FIN);
      ctrl_load_o    = '0;
      ctrl_sum_out_o = '0;
      wb_rd_en_o     = 1'b0;
      wb_addr_o      = '0;
      ib_rd_en_o     = '0;
      ib_addr_o      = '0;
      ob_wr_en_o     = '0;
      ob_addr_o      = '0;
      unique case (state)
         LOAD: begin
            if (cnt < CW'(ROW)) begin
               wb_rd_en_o = 1'b1;
               wb_addr_o  = RW'(CW'(ROW - 1) - cnt);
            end
            if (cnt != '0) begin
               ctrl_load_o = '1;
            end
         end
         COMP: begin
            ctrl_sum_out_o = '1;
            for (int r = 0; r < ROW; r++) begin
               if (cnt >= CW'(r) && cnt < CW'(r) + CW'(n)) begin
                  ib_rd_en_o[r]         = 1'b1;
                  ib_addr_o[r*AW +: AW] = AW'(cnt - CW'(r));
               end
            end
            for (int c = 0; c < COL; c++) begin
               if (cnt >= CW'(LAT + c) &&
                   cnt < CW'(LAT + c) + CW'(n)) begin
                  ob_wr_en_o[c]         = 1'b1;
                  ob_addr_o[c*AW +: AW] = AW'(cnt - CW'(LAT + c));
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (ROW=COL=4, DEPTH=16).
// Walks each run cycle by cycle and checks strobe counts, skew and addresses.
module tb_systolic_ctrl;

   localparam int ROW = 4;
   localparam int COL = 4;
   localparam int DEPTH = 16;
   localparam int AW = 4;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               start = 1'b0;
   logic [AW:0]        num = '0;
   logic               busy;
   logic               done;
   logic [ROW*COL-1:0] ctrl_load;
   logic [ROW*COL-1:0] ctrl_sum_out;
   logic               wb_rd_en;
   logic [1:0]         wb_addr;
   logic [ROW-1:0]     ib_rd_en;
   logic [ROW*AW-1:0]  ib_addr;
   logic [COL-1:0]     ob_wr_en;
   logic [COL*AW-1:0]  ob_addr;

   int errs = 0;
   int checks = 0;

   systolic_ctrl #(
      .WIDTH(8), .ROW(ROW), .COL(COL), .DEPTH(DEPTH)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn),
      .start_i(start),
      .num_vec_i(num),
      .busy_o(busy),
      .done_o(done),
      .ctrl_load_o(ctrl_load),
      .ctrl_sum_out_o(ctrl_sum_out),
      .wb_rd_en_o(wb_rd_en),
      .wb_addr_o(wb_addr),
      .ib_rd_en_o(ib_rd_en),
      .ib_addr_o(ib_addr),
      .ob_wr_en_o(ob_wr_en),
      .ob_addr_o(ob_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_out();
      return {31'd0, (busy | done | (|ctrl_load) | (|ctrl_sum_out) |
              wb_rd_en | (|wb_addr) | (|ib_rd_en) | (|ib_addr) |
              (|ob_wr_en) | (|ob_addr))};
   endfunction

   // One full operation; poke pulses start in COMPUTE t=1 and in DONE.
   task automatic run(input string tag, input int nv, input int n,
                      input int exp_busy, input bit poke);
      int busy_c = 0, done_c = 0, ld_c = 0, ld_first = -1;
      int wb_c = 0, wb_bad = 0, t = -1, so_c = 0, guard = 0;
      int addr_bad = 0, maxa = 0, cyc = 0, a;
      int ib_c[ROW], ob_c[COL], ib_first[ROW], ob_first[COL];
      for (int i = 0; i < ROW; i++) begin
         ib_c[i] = 0;
         ib_first[i] = -1;
      end
      for (int i = 0; i < COL; i++) begin
         ob_c[i] = 0;
         ob_first[i] = -1;
      end
      num = nv[AW:0];
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " busy_rise"}, {31'd0, busy}, 1);
      while (guard < 200) begin
         guard++;
         if (busy) busy_c++;
         if (ctrl_load == '1) begin
            if (ld_first < 0) ld_first = cyc;
            ld_c++;
         end
         if (wb_rd_en) begin
            if (int'(wb_addr) != ROW - 1 - wb_c) wb_bad++;
            wb_c++;
         end
         if (ctrl_sum_out == '1) begin
            t++;
            so_c++;
         end
         for (int r = 0; r < ROW; r++) begin
            a = int'(ib_addr[r*AW +: AW]);
            if (ib_rd_en[r]) begin
               if (a != ib_c[r]) addr_bad++;
               if (ib_c[r] == 0) ib_first[r] = t;
               if (a > maxa) maxa = a;
               ib_c[r]++;
            end else if (a != 0) addr_bad++;
         end
         for (int c = 0; c < COL; c++) begin
            a = int'(ob_addr[c*AW +: AW]);
            if (ob_wr_en[c]) begin
               if (a != ob_c[c]) addr_bad++;
               if (ob_c[c] == 0) ob_first[c] = t;
               if (a > maxa) maxa = a;
               ob_c[c]++;
            end else if (a != 0) addr_bad++;
         end
         start = poke && ((ctrl_sum_out == '1 && t == 1) || done);
         if (done) begin
            done_c++;
            break;
         end
         cyc++;
         step();
      end
      check({tag, " no_timeout"}, {31'd0, guard < 200}, 1);
      step();
      start = 1'b0;
      check({tag, " idle_busy"}, {31'd0, busy}, 0);
      check({tag, " idle_done"}, {31'd0, done}, 0);
      check({tag, " busy_cyc"}, busy_c, exp_busy);
      check({tag, " done_cnt"}, done_c, 1);
      check({tag, " load_cyc"}, ld_c, ROW);
      check({tag, " load_first"}, ld_first, 1);
      check({tag, " wb_cnt"}, wb_c, ROW);
      check({tag, " wb_addr"}, wb_bad, 0);
      check({tag, " sum_cyc"}, so_c, (n == 0) ? 0 : n + ROW + COL);
      check({tag, " addr_seq"}, addr_bad, 0);
      check({tag, " max_addr"}, maxa, (n == 0) ? 0 : n - 1);
      for (int r = 0; r < ROW; r++) begin
         check($sformatf("%s ib_cnt%0d", tag, r), ib_c[r], n);
         check($sformatf("%s ib_t0_%0d", tag, r), ib_first[r],
               (n == 0) ? -1 : r);
      end
      for (int c = 0; c < COL; c++) begin
         check($sformatf("%s ob_cnt%0d", tag, c), ob_c[c], n);
         check($sformatf("%s ob_t0_%0d", tag, c), ob_first[c],
               (n == 0) ? -1 : ROW + 1 + c);
      end
   endtask

   initial begin
      int t, guard, dn;
      #2;
      check("rst_outs", all_out(), 0);
      step();
      step();
      check("rst_hold", all_out(), 0);
      rstn = 1'b1;
      step();
      check("idle_outs", all_out(), 0);

      run("n3", 3, 3, 17, 1'b0);
      run("n0", 0, 0, 6, 1'b0);
      run("n20", 20, 16, 30, 1'b0);
      run("poke", 3, 3, 17, 1'b1);
      run("after_poke", 3, 3, 17, 1'b0);

      num = 5'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      t = -1;
      guard = 0;
      dn = 0;
      while (t < 5 && guard < 100) begin
         guard++;
         if (done) dn++;
         step();
         if (ctrl_sum_out == '1) t++;
      end
      check("rst_reach_t5", t, 5);
      check("rst_busy_pre", {31'd0, busy}, 1);
      rstn = 1'b0;
      #1;
      check("rst_mid_outs", all_out(), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) dn++;
      end
      check("rst_no_done", dn, 0);
      check("rst_mid_hold", all_out(), 0);
      rstn = 1'b1;
      step();
      check("rst_rel_idle", all_out(), 0);

      run("n1", 1, 1, 15, 1'b0);
      run("b2b_n2", 2, 2, 16, 1'b0);
      run("b2b_n5", 5, 5, 19, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
